// File: rtl/timer_pkg.sv
// Shared types, limits and helpers for the HH:MM:SS lap timer.
// Time is kept as six BCD digits; hours are validated against a runtime limit.
package timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef struct packed {
    bcd_t h1;
    bcd_t h0;
    bcd_t m1;
    bcd_t m0;
    bcd_t s1;
    bcd_t s0;
  } time_t;

  localparam int   SEC_MAX    = 59;
  localparam int   MIN_MAX    = 59;
  localparam bcd_t LAMP_DIGIT = 4'd8;
  localparam bcd_t DIG_MAX    = 4'd9;
  localparam bcd_t S1_MAX     = bcd_t'(SEC_MAX / 10);
  localparam bcd_t M1_MAX     = bcd_t'(MIN_MAX / 10);

  function automatic logic bcd_valid(input time_t t, input int hr_max);
    int hours;
    hours = int'(t.h1) * 10 + int'(t.h0);
    return (t.h1 <= DIG_MAX) && (t.h0 <= DIG_MAX) &&
           (t.m1 <= M1_MAX)  && (t.m0 <= DIG_MAX) &&
           (t.s1 <= S1_MAX)  && (t.s0 <= DIG_MAX) &&
           (hours <= hr_max);
  endfunction

  function automatic int prescaler_width(input int tick_div);
    return (tick_div <= 2) ? 1 : $clog2(tick_div);
  endfunction

endpackage

// File: rtl/seg_decoder.sv
// BCD digit to 7-segment pattern, active-high, bit order {g,f,e,d,c,b,a}.
// Non-decimal codes blank the digit.
module seg_decoder (
  input  logic [3:0] digit_i,
  output logic [6:0] seg_o
);

  always_comb begin
    case (digit_i)
      4'd0:    seg_o = 7'h3F;
      4'd1:    seg_o = 7'h06;
      4'd2:    seg_o = 7'h5B;
      4'd3:    seg_o = 7'h4F;
      4'd4:    seg_o = 7'h66;
      4'd5:    seg_o = 7'h6D;
      4'd6:    seg_o = 7'h7D;
      4'd7:    seg_o = 7'h07;
      4'd8:    seg_o = 7'h7F;
      4'd9:    seg_o = 7'h6F;
      default: seg_o = 7'h00;
    endcase
  end

endmodule

// File: rtl/stopwatch_lap_timer_tick_gen.sv
// One-second prescaler: counts 0..TICK_DIV-1 while enabled, holds otherwise.
// tick_o is combinational in the cycle the count sits at its last value.
module stopwatch_lap_timer_tick_gen
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  localparam int         W    = prescaler_width(TICK_DIV);
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/stopwatch_lap_timer.sv
// HH:MM:SS up/down timer with preset load, countdown expiry, lap freeze and lamp test.
// Drives six 7-segment digits; display mux is combinational on registered state.
module stopwatch_lap_timer
  import timer_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000,
  parameter int HR_MAX   = 99
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic        run_i,
  input  logic        mode_down_i,
  input  logic        clear_i,
  input  logic        load_i,
  input  logic [23:0] preset_i,
  input  logic        lap_i,
  input  logic        lamp_test_i,
  output logic [6:0]  seg5_o,
  output logic [6:0]  seg4_o,
  output logic [6:0]  seg3_o,
  output logic [6:0]  seg2_o,
  output logic [6:0]  seg1_o,
  output logic [6:0]  seg0_o,
  output logic        expired_o,
  output logic        wrap_o,
  output logic        load_err_o
);

  localparam bcd_t  HR_H1    = bcd_t'(HR_MAX / 10);
  localparam bcd_t  HR_H0    = bcd_t'(HR_MAX % 10);
  localparam time_t TIME_MAX = {HR_H1, HR_H0, M1_MAX, DIG_MAX, S1_MAX, DIG_MAX};

  time_t time_q, time_d;
  time_t lap_q, lap_d;
  logic  frozen_q, frozen_d;
  logic  expired_q, expired_d;
  logic  wrap_q, wrap_d;
  logic  load_err_q, load_err_d;

  time_t preset_w;
  time_t disp_w;
  logic  load_ok_w;
  logic  tick_w;

  assign preset_w  = preset_i;
  assign load_ok_w = bcd_valid(preset_w, HR_MAX);

  function automatic time_t time_inc(input time_t t);
    time_t r;
    r = t;
    if (r.s0 != DIG_MAX) r.s0 = r.s0 + 4'd1;
    else begin
      r.s0 = '0;
      if (r.s1 != S1_MAX) r.s1 = r.s1 + 4'd1;
      else begin
        r.s1 = '0;
        if (r.m0 != DIG_MAX) r.m0 = r.m0 + 4'd1;
        else begin
          r.m0 = '0;
          if (r.m1 != M1_MAX) r.m1 = r.m1 + 4'd1;
          else begin
            r.m1 = '0;
            if (r.h1 == HR_H1 && r.h0 == HR_H0) begin
              r.h1 = '0;
              r.h0 = '0;
            end else if (r.h0 == DIG_MAX) begin
              r.h0 = '0;
              r.h1 = r.h1 + 4'd1;
            end else begin
              r.h0 = r.h0 + 4'd1;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // Borrow out of 00:00:00 never reaches the hours branch; that case is caught by the caller.
  function automatic time_t time_dec(input time_t t);
    time_t r;
    r = t;
    if (r.s0 != 4'd0) r.s0 = r.s0 - 4'd1;
    else begin
      r.s0 = DIG_MAX;
      if (r.s1 != 4'd0) r.s1 = r.s1 - 4'd1;
      else begin
        r.s1 = S1_MAX;
        if (r.m0 != 4'd0) r.m0 = r.m0 - 4'd1;
        else begin
          r.m0 = DIG_MAX;
          if (r.m1 != 4'd0) r.m1 = r.m1 - 4'd1;
          else begin
            r.m1 = M1_MAX;
            if (r.h0 != 4'd0) r.h0 = r.h0 - 4'd1;
            else if (r.h1 != 4'd0) begin
              r.h0 = DIG_MAX;
              r.h1 = r.h1 - 4'd1;
            end else begin
              r.h1 = HR_H1;
              r.h0 = HR_H0;
            end
          end
        end
      end
    end
    return r;
  endfunction

  // A rejected load freezes the prescaler too, so nothing moves in that cycle.
  stopwatch_lap_timer_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .en_i    (run_i && !expired_q && !load_i),
    .clr_i   (clear_i || (load_i && load_ok_w)),
    .tick_o  (tick_w)
  );

  always_comb begin
    time_d     = time_q;
    lap_d      = lap_q;
    frozen_d   = frozen_q;
    expired_d  = expired_q;
    wrap_d     = 1'b0;
    load_err_d = 1'b0;

    if (clear_i) begin
      time_d    = '0;
      expired_d = 1'b0;
    end else if (load_i) begin
      if (load_ok_w) begin
        time_d    = preset_w;
        expired_d = 1'b0;
      end else begin
        load_err_d = 1'b1;
      end
    end else if (tick_w) begin
      if (mode_down_i) begin
        time_d = (time_q == '0) ? time_q : time_dec(time_q);
        if (time_d == '0) expired_d = 1'b1;
      end else begin
        time_d = time_inc(time_q);
        wrap_d = (time_q == TIME_MAX);
      end
    end

    // Lap captures the value this edge commits, not the stale one.
    if (clear_i) begin
      frozen_d = 1'b0;
    end else if (lap_i) begin
      if (!frozen_q) begin
        lap_d    = time_d;
        frozen_d = 1'b1;
      end else begin
        frozen_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      time_q     <= '0;
      lap_q      <= '0;
      frozen_q   <= 1'b0;
      expired_q  <= 1'b0;
      wrap_q     <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      time_q     <= time_d;
      lap_q      <= lap_d;
      frozen_q   <= frozen_d;
      expired_q  <= expired_d;
      wrap_q     <= wrap_d;
      load_err_q <= load_err_d;
    end
  end

  always_comb begin
    if (lamp_test_i)   disp_w = {6{LAMP_DIGIT}};
    else if (frozen_q) disp_w = lap_q;
    else               disp_w = time_q;
  end

  logic [6:0] seg_w [6];

  for (genvar gi = 0; gi < 6; gi++) begin : g_digit
    seg_decoder u_dec (
      .digit_i (disp_w[gi*4 +: 4]),
      .seg_o   (seg_w[gi])
    );
  end

  assign seg0_o     = seg_w[0];
  assign seg1_o     = seg_w[1];
  assign seg2_o     = seg_w[2];
  assign seg3_o     = seg_w[3];
  assign seg4_o     = seg_w[4];
  assign seg5_o     = seg_w[5];
  assign expired_o  = expired_q;
  assign wrap_o     = wrap_q;
  assign load_err_o = load_err_q;

endmodule

// File: tb/tb_stopwatch_lap_timer.sv
// Scoreboard bench: a seconds-count reference model predicts each cycle's outputs,
// a separate monitor pops and compares them after every rising edge.
module tb_stopwatch_lap_timer;

  localparam int TD     = 4;
  localparam int HMAX   = 23;
  localparam int PERIOD = (HMAX + 1) * 3600;

  logic clk = 1'b0;
  logic rst = 1'b1, run = 1'b0, dn = 1'b0, clr = 1'b0, ld = 1'b0, lp = 1'b0, lt = 1'b0;
  logic [23:0] pre = '0;
  logic [6:0] s5, s4, s3, s2, s1, s0;
  logic expired, wrap, load_err;

  always #5 clk = ~clk;

  stopwatch_lap_timer #(.TICK_DIV(TD), .HR_MAX(HMAX)) dut (
    .clock_i     (clk),
    .reset_i     (rst),
    .run_i       (run),
    .mode_down_i (dn),
    .clear_i     (clr),
    .load_i      (ld),
    .preset_i    (pre),
    .lap_i       (lp),
    .lamp_test_i (lt),
    .seg5_o      (s5),
    .seg4_o      (s4),
    .seg3_o      (s3),
    .seg2_o      (s2),
    .seg1_o      (s1),
    .seg0_o      (s0),
    .expired_o   (expired),
    .wrap_o      (wrap),
    .load_err_o  (load_err)
  );

  typedef struct {
    int          idx;
    logic [41:0] seg;
    logic        ex;
    logic        wr;
    logic        le;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;
  int txn    = 0;

  // Reference model: time as a plain seconds count.
  int m_secs = 0, m_pc = 0, m_lap = 0;
  bit m_frz = 0, m_exp = 0, m_wrap = 0, m_lerr = 0;

  function automatic logic [6:0] seg7(input int d);
    case (d)
      0: return 7'h3F;  1: return 7'h06;  2: return 7'h5B;  3: return 7'h4F;
      4: return 7'h66;  5: return 7'h6D;  6: return 7'h7D;  7: return 7'h07;
      8: return 7'h7F;  9: return 7'h6F;
      default: return 7'h00;
    endcase
  endfunction

  function automatic logic [41:0] show(input int secs);
    int h, m, s;
    h = secs / 3600;
    m = (secs / 60) % 60;
    s = secs % 60;
    return {seg7(h / 10), seg7(h % 10), seg7(m / 10), seg7(m % 10), seg7(s / 10), seg7(s % 10)};
  endfunction

  function automatic bit preset_ok(input logic [23:0] pr, output int secs);
    int h1, h0, m1, m0, t1, t0;
    h1 = int'(pr[23:20]); h0 = int'(pr[19:16]);
    m1 = int'(pr[15:12]); m0 = int'(pr[11:8]);
    t1 = int'(pr[7:4]);   t0 = int'(pr[3:0]);
    secs = (h1 * 10 + h0) * 3600 + (m1 * 10 + m0) * 60 + t1 * 10 + t0;
    return h1 <= 9 && h0 <= 9 && m1 <= 5 && m0 <= 9 && t1 <= 5 && t0 <= 9 && (h1 * 10 + h0) <= HMAX;
  endfunction

  task automatic model_step(input bit r, rn, d, cl, l, input logic [23:0] pr, input bit lap_in);
    bit tick, ok;
    int p;
    tick   = 0;
    m_wrap = 0;
    m_lerr = 0;
    if (r) begin
      m_secs = 0; m_pc = 0; m_lap = 0; m_frz = 0; m_exp = 0;
      return;
    end
    ok = preset_ok(pr, p);
    if (cl || (l && ok)) m_pc = 0;
    else if (!l && rn && !m_exp) begin
      if (m_pc == TD - 1) begin m_pc = 0; tick = 1; end
      else m_pc++;
    end
    if (cl) begin m_secs = 0; m_exp = 0; end
    else if (l) begin
      if (ok) begin m_secs = p; m_exp = 0; end
      else m_lerr = 1;
    end else if (tick) begin
      if (d) begin
        if (m_secs > 0) m_secs--;
        if (m_secs == 0) m_exp = 1;
      end else if (m_secs == PERIOD - 1) begin
        m_secs = 0; m_wrap = 1;
      end else m_secs++;
    end
    if (cl) m_frz = 0;
    else if (lap_in) begin
      if (!m_frz) begin m_lap = m_secs; m_frz = 1; end
      else m_frz = 0;
    end
  endtask

  task automatic step(input bit r, rn, d, cl, l, input logic [23:0] pr, input bit lap_in, lamp);
    exp_t e;
    @(negedge clk);
    rst = r; run = rn; dn = d; clr = cl; ld = l; pre = pr; lp = lap_in; lt = lamp;
    model_step(r, rn, d, cl, l, pr, lap_in);
    e.idx = txn;
    e.seg = lamp ? {6{seg7(8)}} : show(m_frz ? m_lap : m_secs);
    e.ex  = m_exp;
    e.wr  = m_wrap;
    e.le  = m_lerr;
    sb.push_back(e);
    txn++;
  endtask

  task automatic run_n(input int n, input bit d);
    for (int i = 0; i < n; i++) step(0, 1, d, 0, 0, '0, 0, 0);
  endtask

  function automatic logic [23:0] rand_preset();
    int h, m, s;
    if ($urandom_range(0, 3) != 0) begin
      h = $urandom_range(0, HMAX);
      m = $urandom_range(0, 59);
      s = $urandom_range(0, 59);
      return {4'(h / 10), 4'(h % 10), 4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
    end
    return 24'($urandom);
  endfunction

  // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
  initial begin
    exp_t e;
    logic [41:0] got;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e   = sb.pop_front();
        got = {s5, s4, s3, s2, s1, s0};
        checks += 4;
        if (got !== e.seg) begin
          errors++;
          $display("FAIL segs txn=%0d got=%h want=%h", e.idx, got, e.seg);
        end
        if (expired !== e.ex) begin
          errors++;
          $display("FAIL expired txn=%0d got=%b want=%b", e.idx, expired, e.ex);
        end
        if (wrap !== e.wr) begin
          errors++;
          $display("FAIL wrap txn=%0d got=%b want=%b", e.idx, wrap, e.wr);
        end
        if (load_err !== e.le) begin
          errors++;
          $display("FAIL load_err txn=%0d got=%b want=%b", e.idx, load_err, e.le);
        end
        $display("txn %0d segs=%h exp=%b wrap=%b lerr=%b", e.idx, got, expired, wrap, load_err);
      end
    end
  end

  initial begin
    bit rdn;
    // Reset state
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, 0, '0, 0, 0);
    step(0, 0, 0, 0, 0, '0, 0, 0);

    // 60 ticks to 00:01:00, then pause mid-second and resume
    run_n(60 * TD, 0);
    run_n(2, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, '0, 0, 0);
    run_n(2 * TD, 0);

    // Up wrap at HR_MAX:59:59
    step(0, 0, 0, 0, 1, 24'h235958, 0, 0);
    run_n(3 * TD, 0);

    // Countdown to expiry, then hold
    step(0, 0, 1, 0, 1, 24'h000002, 0, 0);
    run_n(2 * TD + 8, 1);

    // Rejected loads, then accepted load coincident with a tick
    step(0, 0, 0, 0, 1, 24'h240000, 0, 0);
    step(0, 0, 0, 0, 1, 24'h006000, 0, 0);
    step(0, 0, 0, 1, 0, '0, 0, 0);
    run_n(1, 0);
    for (int i = 0; i < 2 * TD && m_pc != TD - 1; i++) run_n(1, 0);
    step(0, 1, 0, 0, 1, 24'h123456, 0, 0);
    run_n(TD + 1, 0);

    // Lap freeze at 00:00:05, lamp test while counting
    step(0, 1, 0, 1, 0, '0, 0, 0);
    for (int i = 0; i < 10 * TD && m_secs != 5; i++) run_n(1, 0);
    step(0, 1, 0, 0, 0, '0, 1, 0);
    run_n(3 * TD, 0);
    step(0, 1, 0, 0, 0, '0, 1, 0);
    for (int i = 0; i < 6; i++) step(0, 1, 0, 0, 0, '0, 0, 1);
    run_n(TD, 0);

    // Clear with lap while frozen, then reset mid-count
    step(0, 1, 0, 0, 0, '0, 1, 0);
    run_n(TD + 2, 0);
    step(0, 1, 0, 1, 0, '0, 1, 0);
    run_n(TD + 1, 0);
    step(1, 1, 0, 0, 0, '0, 0, 0);
    run_n(TD + 2, 0);

    // Randomized traffic
    rdn = 0;
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 19) == 0) rdn = ~rdn;
      step($urandom_range(0, 99) == 0,
           $urandom_range(0, 9) != 0,
           rdn,
           $urandom_range(0, 49) == 0,
           $urandom_range(0, 19) == 0,
           rand_preset(),
           $urandom_range(0, 19) == 0,
           $urandom_range(0, 9) == 0);
    end

    @(posedge clk);
    #3;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain got=%0d pending want=0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
